// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard and pending-write count.
// Optional write-through bypass on read and debug ports: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    parameter  int NREAD  = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    wen,
    input  logic [AW-1:0]           wsel,
    input  logic [DATA_W-1:0]       wdat,
    input  logic                    res_en,
    input  logic [AW-1:0]           res_sel,
    input  logic [NREAD*AW-1:0]     rsel,
    output logic [NREAD*DATA_W-1:0] rdat,
    output logic [NREAD-1:0]        rbusy,
    output logic [AW:0]             pending,
    input  logic [AW-1:0]           dbg_sel,
    output logic [DATA_W-1:0]       dbg_dat
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [AW:0]       pending_q;
    logic [AW:0]       pending_d;
    logic              wr_hit;
    logic              res_hit;

    // Qualifying with nRST keeps the bypass path quiet while reset is held.
    assign wr_hit  = wen && nRST && (wsel != '0);
    assign res_hit = res_en && (res_sel != '0);

    // Reserve is applied after the write clear so the new producer wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[wsel] = 1'b0;
        end
        if (res_hit) begin
            busy_d[res_sel] = 1'b1;
        end
        busy_d[0] = 1'b0;
        pending_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            pending_d = pending_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            if (wr_hit) begin
                regs_q[wsel] <= wdat;
            end
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0] sel;
            assign sel = rsel[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            logic byp;
            assign byp = wr_hit && (sel == wsel);
            assign rdat[gi*DATA_W +: DATA_W] = (sel == '0) ? '0 :
                                               byp ? wdat : regs_q[sel];
            assign rbusy[gi] = byp ? (res_hit && (res_sel == wsel)) : busy_q[sel];
`else
            assign rdat[gi*DATA_W +: DATA_W] = (sel == '0) ? '0 : regs_q[sel];
            assign rbusy[gi] = busy_q[sel];
`endif
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    assign dbg_dat = (dbg_sel == '0) ? '0 :
                     (wr_hit && (dbg_sel == wsel)) ? wdat : regs_q[dbg_sel];
`else
    assign dbg_dat = (dbg_sel == '0) ? '0 : regs_q[dbg_sel];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with four read ports; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int NREAD  = 4;
    localparam int AW     = 5;

    logic                    CLK;
    logic                    nRST;
    logic                    wen;
    logic [AW-1:0]           wsel;
    logic [DATA_W-1:0]       wdat;
    logic                    res_en;
    logic [AW-1:0]           res_sel;
    logic [NREAD*AW-1:0]     rsel;
    logic [NREAD*DATA_W-1:0] rdat;
    logic [NREAD-1:0]        rbusy;
    logic [AW:0]             pending;
    logic [AW-1:0]           dbg_sel;
    logic [DATA_W-1:0]       dbg_dat;

    int tests = 0;
    int fails = 0;

    regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .NREAD(NREAD)) dut (
        .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat),
        .res_en(res_en), .res_sel(res_sel), .rsel(rsel), .rdat(rdat),
        .rbusy(rbusy), .pending(pending), .dbg_sel(dbg_sel), .dbg_dat(dbg_dat)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; wsel = '0; wdat = '0; res_en = 1'b0; res_sel = '0;
        #1;
    endtask

    initial begin
        nRST = 1'b0; wen = 1'b0; wsel = '0; wdat = '0; res_en = 1'b0; res_sel = '0;
        rsel = '0; dbg_sel = '0;
        #2;
        chk("reset_rdat", rdat, '0);
        chk("reset_rbusy", rbusy, '0);
        chk("reset_pending", pending, '0);
        chk("reset_dbg", dbg_dat, '0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int r = 0; r < NREGS; r++) begin
            rsel = {4{5'(r)}};
            dbg_sel = 5'(r);
            #1;
            chk($sformatf("init_rdat_r%0d", r), rdat, '0);
            chk($sformatf("init_rbusy_r%0d", r), rbusy, '0);
            chk($sformatf("init_dbg_r%0d", r), dbg_dat, '0);
        end

        // Writes to register 0 are discarded.
        rsel = '0; dbg_sel = '0;
        wen = 1'b1; wsel = 5'd0; wdat = 32'hDEADBEEF;
        tick(); idle();
        chk("r0_rdat", rdat, '0);
        chk("r0_dbg", dbg_dat, '0);
        chk("r0_pending", pending, 6'd0);

        // Reserve reg5 twice, then write it back.
        rsel = {15'd0, 5'd5};
        res_en = 1'b1; res_sel = 5'd5;
        tick(); idle();
        chk("res5a_pending", pending, 6'd1);
        chk("res5a_rbusy", rbusy, 4'b0001);
        res_en = 1'b1; res_sel = 5'd5;
        tick(); idle();
        chk("res5b_pending", pending, 6'd1);
        chk("res5b_rbusy", rbusy, 4'b0001);
        wen = 1'b1; wsel = 5'd5; wdat = 32'h1234;
        tick(); idle();
        chk("wr5_pending", pending, 6'd0);
        chk("wr5_rbusy", rbusy, 4'b0000);
        chk("wr5_rdat0", rdat[31:0], 32'h1234);

        // Same-cycle write and reserve of reg7.
        wen = 1'b1; wsel = 5'd7; wdat = 32'hA5A5A5A5;
        res_en = 1'b1; res_sel = 5'd7;
        tick(); idle();
        rsel = {15'd0, 5'd7}; dbg_sel = 5'd7;
        #1;
        chk("wr_res7_rdat0", rdat[31:0], 32'hA5A5A5A5);
        chk("wr_res7_rbusy", rbusy, 4'b0001);
        chk("wr_res7_pending", pending, 6'd1);
        chk("wr_res7_dbg", dbg_dat, 32'hA5A5A5A5);

        // All ports on reg3 while reg9 is busy.
        wen = 1'b1; wsel = 5'd3; wdat = 32'h55;
        tick(); idle();
        res_en = 1'b1; res_sel = 5'd9;
        tick(); idle();
        chk("res9_pending", pending, 6'd2);
        rsel = {4{5'd3}};
        #1;
        chk("all3_rdat", rdat, {4{32'h55}});
        chk("all3_rbusy", rbusy, 4'b0000);
        rsel = {5'd3, 5'd9, 5'd3, 5'd3};
        #1;
        chk("p2_9_rbusy", rbusy, 4'b0100);
        chk("p2_9_rdat", rdat, {32'h55, 32'h0, 32'h55, 32'h55});

        // Writeback to reg4 observed in the same cycle on port0 and debug.
        res_en = 1'b1; res_sel = 5'd4;
        tick(); idle();
        chk("res4_pending", pending, 6'd3);
        rsel = {15'd0, 5'd4}; dbg_sel = 5'd4;
        wen = 1'b1; wsel = 5'd4; wdat = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp4_rdat0", rdat[31:0], 32'h77);
        chk("byp4_rbusy", rbusy, 4'b0000);
        chk("byp4_dbg", dbg_dat, 32'h77);
`else
        chk("byp4_rdat0", rdat[31:0], 32'h0);
        chk("byp4_rbusy", rbusy, 4'b0001);
        chk("byp4_dbg", dbg_dat, 32'h0);
`endif
        tick(); idle();
        chk("wr4_rdat0", rdat[31:0], 32'h77);
        chk("wr4_rbusy", rbusy, 4'b0000);
        chk("wr4_pending", pending, 6'd2);

        // Write and reserve reg4 together while port0 watches it.
        wen = 1'b1; wsel = 5'd4; wdat = 32'h88;
        res_en = 1'b1; res_sel = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypres4_rdat0", rdat[31:0], 32'h88);
        chk("bypres4_rbusy", rbusy, 4'b0001);
`else
        chk("bypres4_rdat0", rdat[31:0], 32'h77);
        chk("bypres4_rbusy", rbusy, 4'b0000);
`endif
        tick(); idle();
        chk("wrres4_rdat0", rdat[31:0], 32'h88);
        chk("wrres4_rbusy", rbusy, 4'b0001);
        chk("wrres4_pending", pending, 6'd3);

        // Reserve every register, including a no-op on reg0.
        for (int r = 0; r < NREGS; r++) begin
            res_en = 1'b1; res_sel = 5'(r);
            tick();
        end
        idle();
        chk("allbusy_pending", pending, 6'd31);
        rsel = {5'd5, 5'd4, 5'd3, 5'd7}; dbg_sel = 5'd7;
        #1;
        chk("allbusy_rbusy", rbusy, 4'b1111);
        chk("allbusy_rdat", rdat, {32'h1234, 32'h88, 32'h55, 32'hA5A5A5A5});
        chk("allbusy_r0", dut.busy_q[0], 1'b0);

        // Asynchronous reset mid-cycle; outputs clear before any edge.
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_rdat", rdat, '0);
        chk("arst_rbusy", rbusy, '0);
        chk("arst_pending", pending, '0);
        chk("arst_dbg", dbg_dat, '0);

        // Reset held over an edge overrides concurrent write and reserve.
        wen = 1'b1; wsel = 5'd7; wdat = 32'h12345678;
        res_en = 1'b1; res_sel = 5'd5;
        #1;
        chk("rsthold_pre_rdat", rdat, '0);
        tick();
        chk("rsthold_rdat", rdat, '0);
        chk("rsthold_rbusy", rbusy, '0);
        chk("rsthold_pending", pending, '0);
        chk("rsthold_dbg", dbg_dat, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-read-port integer register file with a per-register scoreboard (busy bits) and a pending-write counter.
- Successor to the single-issue 2R/1W file, generalised in data width, depth and read-port count.
- Sits in decode: read ports feed operand fetch, reserve port is driven by issue, write port by writeback.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- DATA_W, 32, data word width in bits
- NREGS, 32, number of architectural registers; power of two, >= 2
- NREAD, 2, number of independent read ports, 1..4
- AW, $clog2(NREGS), register select width; derived, not overridden

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- wen  input  1  writeback enable
- wsel  input  AW  writeback register select
- wdat  input  DATA_W  writeback data
- res_en  input  1  reserve request from issue: mark res_sel busy
- res_sel  input  AW  register to reserve
- rsel  input  NREAD*AW  packed read selects; port i at [i*AW +: AW]
- rdat  output  NREAD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W]
- rbusy  output  NREAD  per-port busy flag for the selected register
- pending  output  AW+1  count of currently busy registers
- dbg_sel  input  AW  debug/observe select
- dbg_dat  output  DATA_W  combinational value of register dbg_sel (0 when dbg_sel == 0)

Behaviour:
- Reset (nRST low, asynchronous): all registers = 0, all busy bits = 0, pending = 0. Combinational outputs follow immediately: rdat = 0, rbusy = 0, dbg_dat = 0.
- Write:
  - On a rising CLK with wen=1 and wsel!=0: reg[wsel] <= wdat and busy[wsel] <= 0.
  - wsel==0 is ignored; no state changes.
- Reserve:
  - On a rising CLK with res_en=1 and res_sel!=0: busy[res_sel] <= 1.
  - res_sel==0 is ignored.
- Same register written and reserved in one cycle (wsel==res_sel, both enabled): data is written and busy ends at 1. The new producer wins.
- Reserving an already-busy register: busy stays 1 and pending is unchanged.
- Writing a non-busy register: data is written and pending is unchanged.
- pending:
  - Next value = popcount of next busy vector; registered, updates on the same edge as busy.
  - Must never exceed NREGS-1.
- Reads are combinational with zero latency:
  - rdat port i = reg[rsel i]; 0 when rsel i == 0.
  - rbusy port i = busy[rsel i].
- All read ports are independent. Any number of ports may select the same register.
- Reset mid-operation overrides any concurrent wen/res_en on that edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through bypass): when wen=1, wsel!=0 and rsel i==wsel in the same cycle:
  - rdat i = wdat.
  - rbusy i = 0, unless res_en=1 with res_sel==wsel, in which case rbusy i = 1.
  - dbg_dat bypasses identically.
- Undefined: reads return the pre-edge register contents and the current busy bit. The consumer sees new data one cycle after writeback.

Test Plan:
- Reset then read all registers on every port -> rdat=0, rbusy=0, pending=0. Write wsel=0 with 0xDEADBEEF -> rsel=0 still reads 0.
- res_en reg5, next cycle res_en reg5 again, then write reg5=0x1234 -> pending goes 1,1,0; rbusy for rsel=5 goes 1,1,0; rdat=0x1234 after the write edge.
- Same-cycle write and reserve of reg7 with 0xA5A5A5A5 -> reg7=0xA5A5A5A5, busy[7]=1, pending=1.
- With NREAD=4: all ports select reg3 (=0x55) while reg9 is busy on another select -> all rdat=0x55. Set rsel port2=9 -> rbusy[2]=1 only.
- Bypass: write reg4=0x77 with rsel0=4 in the same cycle -> rdat0=0x77 and rbusy0=0 with REGFILE_BYPASS_EN; old value and old busy without it.
- Reserve regs 1..31 (NREGS=32), then drop nRST mid-cycle -> pending reads 31 before the drop; all outputs 0 immediately after, with no clock edge required.
